bram_fifo: RTL

BRAM_FIFO -- requirements
Module: bram_fifo

---
 rtl/bram_fifo_pkg.sv | 14 +
 rtl/fifobram_interface.sv | 29 ++
 rtl/simple_dual_port_bram.sv | 33 +++
 rtl/bram_fifo.sv | 92 +++++++++
 4 files changed

// File: rtl/bram_fifo_pkg.sv
// Shared definitions for the BRAM-backed FIFO: default parameter values
// and the almost-full threshold helper used by the top level.
package bram_fifo_pkg;

  localparam int DEFAULT_WIDTH             = 32;
  localparam int DEFAULT_LOG2_DEPTH        = 5;
  localparam int DEFAULT_ALMOSTFULL_MARGIN = 4;

  // Occupancy at which almostfull asserts: usable capacity minus the margin.
  function automatic int afull_threshold(input int log2_depth, input int margin);
    return (1 << log2_depth) - 1 - margin;
  endfunction

endpackage

// File: rtl/fifobram_interface.sv
// Bundle of the FIFO data-path signals. The FIFO itself sits on the
// fifo_source side; the producer/consumer logic uses fifo_sink.
interface fifobram_interface
  import bram_fifo_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int LOG2_DEPTH = DEFAULT_LOG2_DEPTH
);

  logic                  we;
  logic [WIDTH-1:0]      wdata;
  logic                  re;
  logic [WIDTH-1:0]      rdata;
  logic                  rvalid;
  logic                  almostfull;
  logic                  empty;
  logic [LOG2_DEPTH-1:0] count;

  modport fifo_source (
    input  we, wdata, re,
    output rdata, rvalid, almostfull, empty, count
  );

  modport fifo_sink (
    output we, wdata, re,
    input  rdata, rvalid, almostfull, empty, count
  );

endinterface

// File: rtl/simple_dual_port_bram.sv
// Simple dual-port block RAM: one write port, one read port with a
// single-cycle registered output. A read and write to the same address in
// the same cycle returns the old contents.
module simple_dual_port_bram #(
  parameter int WIDTH      = 32,
  parameter int LOG2_DEPTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [LOG2_DEPTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  re,
  input  logic [LOG2_DEPTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [0:(1<<LOG2_DEPTH)-1];

  // Write port.
  // NOTE: the array has no reset so it maps onto block RAM; only the output
  // register below is cleared. Non-blocking writes give read-old-data.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port; holds its value when no read is issued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/bram_fifo.sv
// Single-clock FIFO built on simple_dual_port_bram. Capacity is
// 2**LOG2_DEPTH-1 words; reads return data one cycle after acceptance
// with an rvalid strobe. Port set matches fifobram_interface.fifo_source.
// Optional build macro BRAM_FIFO_ERROR_EN adds sticky overflow/underflow.
module bram_fifo
  import bram_fifo_pkg::*;
#(
  parameter int WIDTH             = DEFAULT_WIDTH,
  parameter int LOG2_DEPTH        = DEFAULT_LOG2_DEPTH,
  parameter int ALMOSTFULL_MARGIN = DEFAULT_ALMOSTFULL_MARGIN
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  re,
  output logic [WIDTH-1:0]      rdata,
  output logic                  rvalid,
  output logic                  almostfull,
  output logic                  empty,
  output logic [LOG2_DEPTH-1:0] count
`ifdef BRAM_FIFO_ERROR_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam logic [LOG2_DEPTH-1:0] MAX_COUNT  = '1;
  localparam logic [LOG2_DEPTH-1:0] AFULL_LEVEL =
    LOG2_DEPTH'(afull_threshold(LOG2_DEPTH, ALMOSTFULL_MARGIN));

  logic [LOG2_DEPTH-1:0] wptr;
  logic [LOG2_DEPTH-1:0] rptr;
  logic                  wr_ok;
  logic                  rd_ok;

  // A write at full is dropped; a read at empty is ignored, so a write into
  // an empty FIFO never falls through to the read port in the same cycle.
  assign wr_ok = we && (count != MAX_COUNT);
  assign rd_ok = re && !empty;

  assign empty      = (count == '0);
  assign almostfull = (count >= AFULL_LEVEL);

  simple_dual_port_bram #(
    .WIDTH      (WIDTH),
    .LOG2_DEPTH (LOG2_DEPTH)
  ) u_bram (
    .clk   (clk),
    .reset (reset),
    .we    (wr_ok),
    .waddr (wptr),
    .wdata (wdata),
    .re    (rd_ok),
    .raddr (rptr),
    .rdata (rdata)
  );

  // Pointers, occupancy and the read-valid strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr   <= '0;
      rptr   <= '0;
      count  <= '0;
      rvalid <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) rptr <= rptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      rvalid <= rd_ok;
    end
  end

`ifdef BRAM_FIFO_ERROR_EN
  // Sticky error flags; only reset clears them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (we && !wr_ok) overflow  <= 1'b1;
      if (re && !rd_ok) underflow <= 1'b1;
    end
  end
`endif

endmodule
